// File: rtl/cpu.sv
// cpu -- multi-cycle 16-bit stack-machine core.
//
// Every instruction passes through FETCH -> DECODE -> EXEC -> WB, one
// cycle each. The instruction word is sampled from the external bus only
// in FETCH. DECODE captures stack/RAM operands, EXEC computes the result
// and checks stack legality, and WB commits all architectural state
// together, so a reset at any point before WB leaves no partial update.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   instruction  [15:11] opcode, [10:0] operand
//   pc           program counter (11 bits, wraps)
//   tos          top of data stack, 0 when the stack is empty
//   dsp          data-stack entry count, 0..2^AWIDTH
//   rsp          return-stack entry count, 0..2^AWIDTH
//   state        FSM state: FETCH=0, DECODE=1, EXEC=2, WB=3
//   err          sticky stack overflow/underflow flag
module cpu #(
    parameter int WIDTH_DATA = 16,
    parameter int AWIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_DATA-1:0] instruction,
    output logic [10:0]           pc,
    output logic [WIDTH_DATA-1:0] tos,
    output logic [AWIDTH:0]       dsp,
    output logic [AWIDTH:0]       rsp,
    output logic [1:0]            state,
    output logic                  err
);

    localparam int             DEPTH_N = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE    = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] TWO    = {{(AWIDTH-1){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_PUSH_I = 5'd1,
        OP_PUSH_M = 5'd2,
        OP_POP_M  = 5'd3,
        OP_ADD    = 5'd4,
        OP_SUB    = 5'd5,
        OP_AND    = 5'd6,
        OP_OR     = 5'd7,
        OP_XOR    = 5'd8,
        OP_NOT    = 5'd9,
        OP_DUP    = 5'd10,
        OP_DROP   = 5'd11,
        OP_JMP    = 5'd16,
        OP_JZ     = 5'd17,
        OP_CALL   = 5'd20,
        OP_RET    = 5'd21
    } opcode_t;

    // Architectural storage
    logic [WIDTH_DATA-1:0] dstack [DEPTH_N];
    logic [10:0]           rstack [DEPTH_N];
    logic [WIDTH_DATA-1:0] ram    [DEPTH_N];

    state_t                cur_state, nxt_state;
    logic [WIDTH_DATA-1:0] ir;
    opcode_t               opcode;
    logic [10:0]           operand;
    logic [AWIDTH-1:0]     addr;

    // Per-state strobes from the FSM output process
    logic ld_ir, ld_ops, ld_exec, commit;

    // Operands captured in DECODE
    logic [WIDTH_DATA-1:0] t_q, n_q, m_q;
    logic [10:0]           r_q;

    // EXEC results (combinational) and their registered copies for WB
    logic                  ok;
    logic [AWIDTH:0]       ds_new, rs_new;
    logic                  ds_wr, rs_wr, ram_wr;
    logic [WIDTH_DATA-1:0] res;
    logic [10:0]           pc_new;

    logic                  ok_q;
    logic [AWIDTH:0]       ds_new_q, rs_new_q;
    logic                  ds_wr_q, rs_wr_q, ram_wr_q;
    logic [WIDTH_DATA-1:0] res_q;
    logic [10:0]           pc_new_q;

    logic [AWIDTH:0]       dsp_m1, dsp_m2, rsp_m1, ds_wr_idx;
    logic [10:0]           pc_inc;

    assign opcode    = opcode_t'(ir[15:11]);
    assign operand   = ir[10:0];
    assign addr      = operand[AWIDTH-1:0];
    assign dsp_m1    = dsp - ONE;
    assign dsp_m2    = dsp - TWO;
    assign rsp_m1    = rsp - ONE;
    assign ds_wr_idx = ds_new_q - ONE;
    assign pc_inc    = pc + 11'd1;

    assign state = cur_state;
    assign tos   = (dsp == '0) ? '0 : dstack[dsp_m1[AWIDTH-1:0]];

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge; blocking here would create
    // order-dependent races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= nxt_state;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            FETCH:  nxt_state = DECODE;
            DECODE: nxt_state = EXEC;
            EXEC:   nxt_state = WB;
            WB:     nxt_state = FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ld_ir   = 1'b0;
        ld_ops  = 1'b0;
        ld_exec = 1'b0;
        commit  = 1'b0;
        unique case (cur_state)
            FETCH:  ld_ir   = 1'b1;
            DECODE: ld_ops  = 1'b1;
            EXEC:   ld_exec = 1'b1;
            WB:     commit  = 1'b1;
        endcase
    end

    // ---------------- EXEC: result and legality ----------------
    // Binary ops take a = second entry (n_q), b = top (t_q).
    always_comb begin
        ok     = 1'b1;
        ds_new = dsp;
        ds_wr  = 1'b0;
        res    = t_q;
        rs_new = rsp;
        rs_wr  = 1'b0;
        ram_wr = 1'b0;
        pc_new = pc_inc;
        case (opcode)
            OP_PUSH_I: begin
                ok = (dsp != DEPTH); ds_new = dsp + ONE; ds_wr = 1'b1;
                res = {{(WIDTH_DATA-11){1'b0}}, operand};
            end
            OP_PUSH_M: begin
                ok = (dsp != DEPTH); ds_new = dsp + ONE; ds_wr = 1'b1; res = m_q;
            end
            OP_POP_M: begin
                ok = (dsp != '0); ds_new = dsp_m1; ram_wr = 1'b1;
            end
            OP_ADD: begin ok = (dsp >= TWO); ds_new = dsp_m1; ds_wr = 1'b1; res = n_q + t_q; end
            OP_SUB: begin ok = (dsp >= TWO); ds_new = dsp_m1; ds_wr = 1'b1; res = n_q - t_q; end
            OP_AND: begin ok = (dsp >= TWO); ds_new = dsp_m1; ds_wr = 1'b1; res = n_q & t_q; end
            OP_OR:  begin ok = (dsp >= TWO); ds_new = dsp_m1; ds_wr = 1'b1; res = n_q | t_q; end
            OP_XOR: begin ok = (dsp >= TWO); ds_new = dsp_m1; ds_wr = 1'b1; res = n_q ^ t_q; end
            OP_NOT: begin ok = (dsp != '0); ds_wr = 1'b1; res = ~t_q; end
            OP_DUP: begin
                ok = (dsp != '0) && (dsp != DEPTH); ds_new = dsp + ONE; ds_wr = 1'b1;
            end
            OP_DROP: begin ok = (dsp != '0); ds_new = dsp_m1; end
            OP_JMP:  pc_new = operand;
            OP_JZ: begin
                ok = (dsp != '0); ds_new = dsp_m1;
                pc_new = (t_q == '0) ? operand : pc_inc;
            end
            OP_CALL: begin
                ok = (rsp != DEPTH); rs_new = rsp + ONE; rs_wr = 1'b1; pc_new = operand;
            end
            OP_RET: begin ok = (rsp != '0); rs_new = rsp_m1; pc_new = r_q; end
            default: ;
        endcase
        // An illegal stack access commits nothing except the pc advance.
        if (!ok) begin
            ds_new = dsp;
            ds_wr  = 1'b0;
            rs_new = rsp;
            rs_wr  = 1'b0;
            ram_wr = 1'b0;
            pc_new = pc_inc;
        end
    end

    // ---------------- Control and architectural registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ir       <= '0;
            pc       <= '0;
            dsp      <= '0;
            rsp      <= '0;
            err      <= 1'b0;
            ok_q     <= 1'b1;
            ds_new_q <= '0;
            rs_new_q <= '0;
            ds_wr_q  <= 1'b0;
            rs_wr_q  <= 1'b0;
            ram_wr_q <= 1'b0;
            pc_new_q <= '0;
        end else begin
            if (ld_ir) ir <= instruction;
            if (ld_exec) begin
                ok_q     <= ok;
                ds_new_q <= ds_new;
                rs_new_q <= rs_new;
                ds_wr_q  <= ds_wr;
                rs_wr_q  <= rs_wr;
                ram_wr_q <= ram_wr;
                pc_new_q <= pc_new;
            end
            if (commit) begin
                pc  <= pc_new_q;
                dsp <= ds_new_q;
                rsp <= rs_new_q;
                err <= err | ~ok_q;
            end
        end
    end

    // ---------------- Datapath registers (no reset needed) ----------------
    // Out-of-range reads when a stack is empty are harmless: EXEC flags
    // such instructions illegal and discards their results.
    always_ff @(posedge clk) begin
        if (ld_ops) begin
            t_q <= dstack[dsp_m1[AWIDTH-1:0]];
            n_q <= dstack[dsp_m2[AWIDTH-1:0]];
            m_q <= ram[addr];
            r_q <= rstack[rsp_m1[AWIDTH-1:0]];
        end
        if (ld_exec) res_q <= res;
    end

    // ---------------- Stack and RAM writes ----------------
    // NOTE: storage arrays are deliberately not reset; the valid region is
    // defined by dsp/rsp, and a reset would prevent mapping to RAM cells.
    // Writes are gated by reset so an abort in WB commits nothing.
    always_ff @(posedge clk) begin
        if (commit && !reset) begin
            if (ds_wr_q)  dstack[ds_wr_idx[AWIDTH-1:0]] <= res_q;
            if (rs_wr_q)  rstack[rsp[AWIDTH-1:0]]       <= pc_inc;
            if (ram_wr_q) ram[addr]                     <= t_q;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: a table of directed instructions with
// hand-computed architectural state after each, plus hand-written
// sequences for reset abort, call/return, held bus and stack limits.
module tb_cpu;

    localparam logic [4:0] NOP = 5'd0, PUSH_I = 5'd1, PUSH_M = 5'd2, POP_M = 5'd3,
                           ADD = 5'd4, SUB = 5'd5, AND_ = 5'd6, OR_ = 5'd7,
                           XOR_ = 5'd8, NOT_ = 5'd9, DUP = 5'd10, DROP = 5'd11,
                           JMP = 5'd16, JZ = 5'd17, CALL = 5'd20, RET = 5'd21,
                           UNDEF = 5'd31;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [10:0] pc;
    logic [15:0] tos;
    logic [5:0]  dsp;
    logic [5:0]  rsp;
    logic [1:0]  state;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu #(.WIDTH_DATA(16), .AWIDTH(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .pc          (pc),
        .tos         (tos),
        .dsp         (dsp),
        .rsp         (rsp),
        .state       (state),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [10:0] pc;
        logic [15:0] tos;
        logic [5:0]  dsp;
        logic [5:0]  rsp;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_arch(input string name, input logic [10:0] e_pc, input logic [15:0] e_tos,
                              input logic [5:0] e_dsp, input logic [5:0] e_rsp, input logic e_err);
        check({name, ".pc"},  32'(pc),  32'(e_pc));
        check({name, ".tos"}, 32'(tos), 32'(e_tos));
        check({name, ".dsp"}, 32'(dsp), 32'(e_dsp));
        check({name, ".rsp"}, 32'(rsp), 32'(e_rsp));
        check({name, ".err"}, 32'(err), 32'(e_err));
    endtask

    // Present one instruction for exactly one 4-cycle instruction slot.
    task automatic do_instr(input logic [15:0] w);
        instruction = w;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        instruction = ins(NOP, 11'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- reset state ----
        check("rst.state", 32'(state), 32'd0);
        check_arch("rst", 11'd0, 16'h0000, 6'd0, 6'd0, 1'b0);

        // ---- reset asserted during EXEC of PUSH_I aborts it ----
        instruction = ins(PUSH_I, 11'd3);
        repeat (2) @(posedge clk);
        #1;
        check("abort.in_exec", 32'(state), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.state", 32'(state), 32'd0);
        check_arch("abort", 11'd0, 16'h0000, 6'd0, 6'd0, 1'b0);

        // ---- main table ----
        vecs.push_back('{ins(PUSH_I, 11'd5),     11'd1,   16'h0005, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'd2),     11'd2,   16'h0002, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(ADD,    11'd0),     11'd3,   16'h0007, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'd9),     11'd4,   16'h0009, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(SUB,    11'd0),     11'd5,   16'hFFFE, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'h0F0),   11'd6,   16'h00F0, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(AND_,   11'd0),     11'd7,   16'h00F0, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'h00F),   11'd8,   16'h000F, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(OR_,    11'd0),     11'd9,   16'h00FF, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'h0F0),   11'd10,  16'h00F0, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(XOR_,   11'd0),     11'd11,  16'h000F, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(NOT_,   11'd0),     11'd12,  16'hFFF0, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(DUP,    11'd0),     11'd13,  16'hFFF0, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(DROP,   11'd0),     11'd14,  16'hFFF0, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'h7FF),   11'd15,  16'h07FF, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(POP_M,  11'd3),     11'd16,  16'hFFF0, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_M, 11'd3),     11'd17,  16'h07FF, 6'd2, 6'd0, 1'b0});
        vecs.push_back('{ins(DROP,   11'd0),     11'd18,  16'hFFF0, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(DROP,   11'd0),     11'd19,  16'h0000, 6'd0, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'd0),     11'd20,  16'h0000, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(JZ,     11'd100),   11'd100, 16'h0000, 6'd0, 6'd0, 1'b0});
        vecs.push_back('{ins(PUSH_I, 11'd1),     11'd101, 16'h0001, 6'd1, 6'd0, 1'b0});
        vecs.push_back('{ins(JZ,     11'd200),   11'd102, 16'h0000, 6'd0, 6'd0, 1'b0});
        vecs.push_back('{ins(JMP,    11'h7FF),   11'h7FF, 16'h0000, 6'd0, 6'd0, 1'b0});
        vecs.push_back('{ins(NOP,    11'd0),     11'd0,   16'h0000, 6'd0, 6'd0, 1'b0});
        vecs.push_back('{ins(UNDEF,  11'd55),    11'd1,   16'h0000, 6'd0, 6'd0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            do_instr(vecs[i].instr);
            check_arch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].tos,
                       vecs[i].dsp, vecs[i].rsp, vecs[i].err);
        end

        // ---- CALL / RET, RET bus held for 8 cycles executes twice ----
        do_reset();
        do_instr(ins(CALL, 11'd5));
        check_arch("call5", 11'd5, 16'h0000, 6'd0, 6'd1, 1'b0);
        do_instr(ins(CALL, 11'd4));
        check_arch("call4", 11'd4, 16'h0000, 6'd0, 6'd2, 1'b0);
        instruction = ins(RET, 11'd0);
        repeat (4) @(posedge clk);
        #1;
        check_arch("ret1", 11'd6, 16'h0000, 6'd0, 6'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_arch("ret2", 11'd1, 16'h0000, 6'd0, 6'd0, 1'b0);

        // ---- RET on empty return stack: pc advances, err sticks ----
        do_instr(ins(RET, 11'd0));
        check_arch("ret_empty", 11'd2, 16'h0000, 6'd0, 6'd0, 1'b1);
        do_instr(ins(NOP, 11'd0));
        do_instr(ins(NOP, 11'd0));
        check_arch("err_sticky", 11'd4, 16'h0000, 6'd0, 6'd0, 1'b1);
        do_reset();
        check("err_clear", 32'(err), 32'd0);

        // ---- data stack overflow ----
        for (int i = 1; i <= 32; i++) do_instr(ins(PUSH_I, 11'(i)));
        check_arch("full", 11'd32, 16'd32, 6'd32, 6'd0, 1'b0);
        do_instr(ins(PUSH_I, 11'd1));
        check_arch("overflow", 11'd33, 16'd32, 6'd32, 6'd0, 1'b1);

        // ---- binary op underflow ----
        do_reset();
        do_instr(ins(PUSH_I, 11'd1));
        do_instr(ins(ADD, 11'd0));
        check_arch("add_underflow", 11'd2, 16'h0001, 6'd1, 6'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Multi-cycle, 16-bit stack-machine CPU core.
- Instructions arrive on an external `instruction` bus; the core has no instruction memory.
- Contains a data stack, a return stack, a small data RAM and a program counter; every instruction runs through a fixed 4-state FSM.
- Debug outputs expose architectural state for verification and top-level integration.

Parameters:
- WIDTH_DATA, 16, data word and instruction width (instruction layout assumes 16).
- AWIDTH, 5, address width; data stack, return stack and data RAM each hold 2^AWIDTH entries.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- instruction  input  WIDTH_DATA  [15:11] opcode, [10:0] operand.
- pc  output  11  program counter.
- tos  output  WIDTH_DATA  top of data stack; 0 when empty.
- dsp  output  AWIDTH+1  data-stack entry count, 0..2^AWIDTH.
- rsp  output  AWIDTH+1  return-stack entry count.
- state  output  2  FSM state: FETCH=0, DECODE=1, EXEC=2, WB=3.
- err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (sampled on clk edge): state=FETCH, pc=0, dsp=0, rsp=0, err=0, tos=0, IR=0. Stack and RAM contents are not cleared.
- Reset asserted in any state aborts the current instruction; no partial commit.
- FSM: FETCH→DECODE→EXEC→WB→FETCH, one cycle each. Every instruction takes exactly 4 cycles.
- FETCH: IR <= instruction. The bus is sampled only in FETCH, so a value held for 8 cycles executes twice.
- DECODE: split opcode/operand; read the needed stack/RAM operands into internal registers.
- EXEC: compute result and stack-legality check.
- WB: commit stacks, RAM, pc and err.
- pc update: pc <= pc+1 (mod 2^11) in WB unless the opcode sets pc.
- Opcodes (operand = IR[10:0]; addr = operand[AWIDTH-1:0]):
  - 0 NOP: no effect.
  - 1 PUSH_I: push zero-extended operand.
  - 2 PUSH_M: push RAM[addr].
  - 3 POP_M: RAM[addr] <= tos, pop.
  - 4 ADD: pop b, pop a, push a+b.
  - 5 SUB: push a-b.
  - 6 AND, 7 OR, 8 XOR: bitwise, same two-operand pattern as ADD.
  - 9 NOT: tos <= ~tos; needs 1 entry.
  - 10 DUP: push copy of tos.
  - 11 DROP: pop.
  - 16 JMP: pc <= operand.
  - 17 JZ: pop; pc <= operand if the popped value was 0, else pc+1.
  - 20 CALL: push pc+1 on return stack; pc <= operand.
  - 21 RET: pc <= pop of return stack.
  - All other opcodes: treated as NOP.
- Arithmetic is modulo 2^WIDTH_DATA; no carry or overflow flags.
- Boundary conditions:
  - Push to a full stack, or pop needing more entries than present: the instruction commits nothing (stacks, RAM unchanged), pc <= pc+1, err <= 1.
  - A failed RET or CALL also advances pc by 1.
  - err clears only on reset.
  - Binary ops need dsp≥2; a net result leaves dsp-1.
- The return stack is independent of the data stack; both have depth 2^AWIDTH.

Test Plan:
- Reset → state=0, pc=0, dsp=0, rsp=0, err=0, tos=0. Assert reset mid-EXEC of PUSH_I → same values; dsp not incremented.
- PUSH_I 5, PUSH_I 2, ADD (4 cycles each) → tos=7, dsp=1, pc=3. Then PUSH_I 9, SUB → tos=0xFFFE (7-9), dsp=1.
- From reset: CALL 5 → pc=5, rsp=1. CALL 4 → pc=4, rsp=2. RET held 8 cycles → pc=6 after first, pc=1 after second, rsp=0, err=0.
- RET with rsp=0 → pc=pc+1, rsp=0, err=1; err stays 1 across NOPs until reset.
- Push 32 times, then PUSH_I 1 → dsp stays 32, tos unchanged, err=1. ADD with dsp=1 → no change, err=1.
- PUSH_I 0x7FF, POP_M 3, PUSH_M 3 → tos=0x07FF, dsp=1. PUSH_I 0, JZ 100 → pc=100, dsp=1.
